// File: rtl/cpu_sequencer_if.sv
// Sequencer-side bus bundle: instruction fetch, register file, data memory and debug.
// Latency: pure wiring, no storage.
// Backpressure: none; run gates new fetches at the instruction boundary.
interface cpu_sequencer_if;
  logic       run;
  logic [7:0] instr_addr;
  logic [7:0] instr;
  logic [1:0] read_reg1;
  logic [1:0] read_reg2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;
  logic       reg_write;
  logic [1:0] write_reg;
  logic [7:0] write_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic [2:0] state;
  logic       retire;

  // Sequencer side.
  modport master (
    input  run, instr, read_data1, read_data2, mem_rdata,
    output instr_addr, read_reg1, read_reg2, reg_write, write_reg, write_data,
           mem_addr, mem_wdata, mem_we, state, retire
  );

  // Memories / register file / debug side.
  modport slave (
    output run, instr, read_data1, read_data2, mem_rdata,
    input  instr_addr, read_reg1, read_reg2, reg_write, write_reg, write_data,
           mem_addr, mem_wdata, mem_we, state, retire
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/READ/EXEC/MEM/WB sequencer for the 8-bit 4-register CPU.
// Latency: ADD 4, LW 5, SW 4, J 3 cycles from FETCH to the retire pulse.
// Backpressure: none downstream; run=0 parks the FSM in FETCH between instructions.
module cpu_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input logic             clk,
  input logic             reset_n,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] pc_q, pc_d;
  logic [1:0] rr1_q, rr1_d;
  logic [1:0] rr2_q, rr2_d;
  logic       rw_q, rw_d;
  logic [1:0] wreg_q, wreg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] maddr_q, maddr_d;
  logic [7:0] mwdata_q, mwdata_d;
  logic       mwe_q, mwe_d;
  logic       retire_q, retire_d;

  logic [1:0] op;
  logic [7:0] imm2_sx;
  logic [7:0] off6_sx;

  assign op      = ir_q[7:6];
  assign imm2_sx = {{6{ir_q[1]}}, ir_q[1:0]};
  assign off6_sx = {{2{ir_q[5]}}, ir_q[5:0]};

  // Next-state and next-output decode; every output is a register, so this computes its next value.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    rr1_d    = rr1_q;
    rr2_d    = rr2_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rw_d     = 1'b0;
    mwe_d    = 1'b0;
    retire_d = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.run) begin
          // Selects come straight from the fetched word so they are stable for the whole READ cycle.
          ir_d    = bus.instr;
          rr1_d   = bus.instr[5:4];
          rr2_d   = bus.instr[3:2];
          state_d = READ;
        end
      end
      READ: begin
        // A jump finishes in EXEC, so its retire pulse is armed here.
        retire_d = (op == OP_J);
        state_d  = EXEC;
      end
      EXEC: begin
        case (op)
          OP_ADD: begin
            wreg_d   = ir_q[1:0];
            wdata_d  = bus.read_data1 + bus.read_data2;
            rw_d     = 1'b1;
            retire_d = 1'b1;
            state_d  = WB;
          end
          OP_LW: begin
            maddr_d = bus.read_data1 + imm2_sx;
            state_d = MEM;
          end
          OP_SW: begin
            maddr_d  = bus.read_data1 + imm2_sx;
            mwdata_d = bus.read_data2;
            mwe_d    = 1'b1;
            retire_d = 1'b1;
            state_d  = MEM;
          end
          default: begin
            pc_d    = pc_q + 8'd1 + off6_sx;
            state_d = FETCH;
          end
        endcase
      end
      MEM: begin
        if (op == OP_LW) begin
          wreg_d   = ir_q[3:2];
          wdata_d  = bus.mem_rdata;
          rw_d     = 1'b1;
          retire_d = 1'b1;
          state_d  = WB;
        end else begin
          pc_d    = pc_q + 8'd1;
          state_d = FETCH;
        end
      end
      WB: begin
        pc_d    = pc_q + 8'd1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM state register; reset returns to FETCH even mid-instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Datapath and output registers; reset drops any pending write or store strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_q     <= 8'h00;
      pc_q     <= PC_RESET;
      rr1_q    <= 2'd0;
      rr2_q    <= 2'd0;
      rw_q     <= 1'b0;
      wreg_q   <= 2'd0;
      wdata_q  <= 8'h00;
      maddr_q  <= 8'h00;
      mwdata_q <= 8'h00;
      mwe_q    <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      rr1_q    <= rr1_d;
      rr2_q    <= rr2_d;
      rw_q     <= rw_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
      retire_q <= retire_d;
    end
  end

  assign bus.instr_addr = pc_q;
  assign bus.read_reg1  = rr1_q;
  assign bus.read_reg2  = rr2_q;
  assign bus.reg_write  = rw_q;
  assign bus.write_reg  = wreg_q;
  assign bus.write_data = wdata_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.mem_we     = mwe_q;
  assign bus.state      = state_q;
  assign bus.retire     = retire_q;

endmodule
